traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Parametrised two-way intersection controller and the next generation of the fixed-timing WE/NS controller. Phase durations are given in seconds through parameters and scaled by an internal one-second tick prescaler. It adds a latched pedestrian-request walk phase and a flashing-yellow night mode. It sits directly between the board clock/reset and the lamp drivers.

## Interface
- CLK_PER_SEC, default 50_000_000: clk cycles per second; must be ≥ 2.
- GREEN_SEC, default 14: green duration per direction, in seconds; must be ≥ 1.
- YELLOW_SEC, default 3: yellow duration, in seconds; must be ≥ 1.
- ALLRED_SEC, default 3: all-red clearance duration, in seconds; must be ≥ 1.
- WALK_SEC, default 10: pedestrian walk duration, in seconds; must be ≥ 1.
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- ped_req  in  1  pedestrian button; a one-cycle pulse or any longer level is accepted.
- flash_en  in  1  night-mode request, level-sensitive.
- lightWE  out  3  WE lamps as {red, yellow, green}, one-hot or 000.
- lightNS  out  3  NS lamps, same encoding.
- walk  out  1  pedestrian walk lamp.

## Operation
- Lamp codes: green = 001, yellow = 010, red = 100, off = 000.
- States and outputs (WE, NS, walk):
  - WE_GREEN: 001, 100, 0
  - WE_YELLOW: 010, 100, 0
  - CLR_A: 100, 100, 0
  - NS_GREEN: 100, 001, 0
  - NS_YELLOW: 100, 010, 0
  - CLR_B: 100, 100, 0
  - PED_WALK: 100, 100, 1
  - FLASH: both lamps = 010 when blink = 1, 000 when blink = 0; walk = 0
- Reset values: state = WE_GREEN, prescaler = 0, sec_cnt = 0, ped_pend = 0, blink = 1. Outputs are therefore lightWE = 001, lightNS = 100, walk = 0.
- Fixed sequence: WE_GREEN → WE_YELLOW → CLR_A → NS_GREEN → NS_YELLOW → CLR_B → WE_GREEN.
- Exit of CLR_A, in priority order: flash_en = 1 → FLASH; otherwise → NS_GREEN.
- Exit of CLR_B, in priority order: flash_en = 1 → FLASH; ped_pend = 1 → PED_WALK; otherwise → WE_GREEN.
- PED_WALK → CLR_B.
- FLASH: stays while flash_en = 1. When flash_en = 0 is sampled on a tick, moves to CLR_B. Does not wait for a full duration.
- flash_en is sampled only at clearance exits and on FLASH ticks. A green or yellow phase is never cut short.
- ped_pend:
  - Set by ped_req = 1 in any state except PED_WALK.
  - Cleared on entry to PED_WALK.
  - ped_req in the entry cycle of PED_WALK is absorbed.
  - ped_req during PED_WALK is ignored.
  - A pending request survives FLASH and is served at the next CLR_B exit with flash_en = 0.
- Blink toggles on every tick while in FLASH and is forced to 1 on FLASH entry.

## Timing
- Prescaler counts 0 … CLK_PER_SEC−1. tick = 1 on the cycle where count = CLK_PER_SEC−1, then it wraps to 0.
- sec_cnt increments on tick.
- A state with duration D exits on the tick where sec_cnt = D−1.
- On every state change, prescaler and sec_cnt clear to 0. Each state therefore lasts exactly D × CLK_PER_SEC cycles.
- Outputs are a Moore decode of the state register. They change in the cycle after the transition edge, with no further latency.
- ped_req sampled at edge n sets ped_pend visible at n+1. It is honoured if it arrives up to and including the CLR_B exit-decision cycle.
- Width rule: prescaler width = $clog2(CLK_PER_SEC). sec_cnt width = $clog2 of the maximum of all *_SEC parameters, plus 1. No counter may overflow for legal parameters.
- rst asserted mid-phase or mid-FLASH returns all state to reset values at the next edge, and the pending request is dropped.

## Structure
- Package traffic_light_pkg holds:
  - the state enum;
  - lamp code constants (LAMP_RED/YEL/GRN/OFF);
  - the lamp-field index constants.
- Sub-module tick_gen (parameter CLK_PER_SEC; ports clk, rst, clr, tick) holds the prescaler. The FSM drives clr on every state change.
- The FSM, sec_cnt, ped_pend and blink stay in traffic_light_ctrl.

## Test plan
All scenarios use CLK_PER_SEC = 4, GREEN_SEC = 3, YELLOW_SEC = 1, ALLRED_SEC = 1, WALK_SEC = 2.
- Reset then free run → outputs 001/100 right after reset. Phases last 12/4/4/12/4/4 cycles. Full cycle = 40 cycles, and the sequence repeats.
- 1-cycle ped_req pulse during NS_GREEN → PED_WALK (walk = 1, both lamps 100) for 8 cycles after CLR_B. Then CLR_B 4 cycles, then WE_GREEN. A second pulse during PED_WALK causes no extra walk.
- flash_en raised mid WE_GREEN → green completes all 12 cycles. FLASH is entered at the CLR_A exit. Both lamps alternate 010/000 every 4 cycles, starting with 010.
- flash_en dropped during FLASH → exit on the next tick to CLR_B (100/100, 4 cycles), then WE_GREEN.
- ped_req and flash_en both set before the CLR_B exit → FLASH wins. After flash_en drops: CLR_B → PED_WALK.
- rst pulsed mid NS_YELLOW with ped_pend = 1 → the next cycle shows 001/100 and walk = 0. No PED_WALK follows in the first cycle.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the two-way intersection controller.
package traffic_light_pkg;

  typedef enum logic [2:0] {
    StWeGreen,
    StWeYellow,
    StClrA,
    StNsGreen,
    StNsYellow,
    StClrB,
    StPedWalk,
    StFlash
  } state_e;

  // Lamp field positions within a {red, yellow, green} lamp vector.
  localparam int unsigned LAMP_R_IDX = 2;
  localparam int unsigned LAMP_Y_IDX = 1;
  localparam int unsigned LAMP_G_IDX = 0;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_light_if.sv
// Request inputs and lamp outputs of the intersection controller.
// master: the environment (buttons, night switch); slave: the controller.
interface traffic_light_if;
  logic       ped_req;
  logic       flash_en;
  logic [2:0] lightWE;
  logic [2:0] lightNS;
  logic       walk;

  modport master (
    output ped_req,
    output flash_en,
    input  lightWE,
    input  lightNS,
    input  walk
  );

  modport slave (
    input  ped_req,
    input  flash_en,
    output lightWE,
    output lightNS,
    output walk
  );
endinterface

// File: rtl/tick_gen.sv
// One-second tick prescaler; clr restarts the second so every phase
// begins on a fresh count.
module tick_gen #(
  parameter int unsigned CLK_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] CNT_MAX = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0] cnt_q;

  assign tick = (cnt_q == CNT_MAX);

  // Count 0..CLK_PER_SEC-1, wrapping on tick or restarting on clr.
  always_ff @(posedge clk) begin
    if (rst || clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PW'(1);
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller with pedestrian walk phase and
// flashing-yellow night mode. Lamps are registered Moore outputs.
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 50_000_000,
  parameter int unsigned GREEN_SEC   = 14,
  parameter int unsigned YELLOW_SEC  = 3,
  parameter int unsigned ALLRED_SEC  = 3,
  parameter int unsigned WALK_SEC    = 10
) (
  input  logic            clk,
  input  logic            rst,
  traffic_light_if.slave  bus
);

  localparam int unsigned MAX_SEC =
      max_u(max_u(GREEN_SEC, YELLOW_SEC), max_u(ALLRED_SEC, WALK_SEC));
  localparam int unsigned SW = $clog2(MAX_SEC) + 1;

  typedef logic [SW-1:0] sec_t;

  localparam sec_t GREEN_LAST  = sec_t'(GREEN_SEC - 1);
  localparam sec_t YELLOW_LAST = sec_t'(YELLOW_SEC - 1);
  localparam sec_t ALLRED_LAST = sec_t'(ALLRED_SEC - 1);
  localparam sec_t WALK_LAST   = sec_t'(WALK_SEC - 1);

  state_e     state_q, state_d;
  sec_t       sec_cnt_q, sec_cnt_d;
  logic       ped_pend_q, ped_pend_d;
  logic       blink_q, blink_d;
  logic [2:0] we_q, we_d;
  logic [2:0] ns_q, ns_d;
  logic       walk_q, walk_d;

  logic tick;
  logic state_chg;
  logic phase_done;
  sec_t dur_last;

  tick_gen #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (state_chg),
    .tick(tick)
  );

  // Last second index of the current timed phase.
  always_comb begin
    dur_last = GREEN_LAST;
    unique case (state_q)
      StWeGreen, StNsGreen:  dur_last = GREEN_LAST;
      StWeYellow, StNsYellow: dur_last = YELLOW_LAST;
      StClrA, StClrB:        dur_last = ALLRED_LAST;
      StPedWalk:             dur_last = WALK_LAST;
      StFlash:               dur_last = '0;
    endcase
  end

  assign phase_done = tick && (sec_cnt_q == dur_last);

  // Next state; flash_en is only looked at on clearance exits and FLASH ticks.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWeGreen:  if (phase_done) state_d = StWeYellow;
      StWeYellow: if (phase_done) state_d = StClrA;
      StClrA: begin
        if (phase_done) state_d = bus.flash_en ? StFlash : StNsGreen;
      end
      StNsGreen:  if (phase_done) state_d = StNsYellow;
      StNsYellow: if (phase_done) state_d = StClrB;
      StClrB: begin
        if (phase_done) begin
          if (bus.flash_en) begin
            state_d = StFlash;
          end else if (ped_pend_q || bus.ped_req) begin
            // A press in the decision cycle itself still counts.
            state_d = StPedWalk;
          end else begin
            state_d = StWeGreen;
          end
        end
      end
      StPedWalk:  if (phase_done) state_d = StClrB;
      StFlash:    if (tick && !bus.flash_en) state_d = StClrB;
    endcase
  end

  assign state_chg = (state_d != state_q);

  // Counters, pedestrian latch and blink phase.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    if (state_chg || (state_q == StFlash)) begin
      // FLASH is untimed, so its second counter is held to avoid wrap.
      sec_cnt_d = '0;
    end else if (tick) begin
      sec_cnt_d = sec_cnt_q + sec_t'(1);
    end

    ped_pend_d = ped_pend_q;
    if (state_chg && (state_d == StPedWalk)) begin
      ped_pend_d = 1'b0;
    end else if ((state_q != StPedWalk) && bus.ped_req) begin
      ped_pend_d = 1'b1;
    end

    blink_d = blink_q;
    if (state_chg && (state_d == StFlash)) begin
      blink_d = 1'b1;
    end else if ((state_q == StFlash) && tick) begin
      blink_d = ~blink_q;
    end
  end

  // Lamp decode of the upcoming state so outputs track the state register.
  always_comb begin
    we_d   = LAMP_RED;
    ns_d   = LAMP_RED;
    walk_d = 1'b0;
    unique case (state_d)
      StWeGreen:  we_d = LAMP_GRN;
      StWeYellow: we_d = LAMP_YEL;
      StClrA:     ;
      StNsGreen:  ns_d = LAMP_GRN;
      StNsYellow: ns_d = LAMP_YEL;
      StClrB:     ;
      StPedWalk:  walk_d = 1'b1;
      StFlash: begin
        we_d = blink_d ? LAMP_YEL : LAMP_OFF;
        ns_d = blink_d ? LAMP_YEL : LAMP_OFF;
      end
    endcase
  end

  // Controller state and registered lamp outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StWeGreen;
      sec_cnt_q  <= '0;
      ped_pend_q <= 1'b0;
      blink_q    <= 1'b1;
      we_q       <= LAMP_GRN;
      ns_q       <= LAMP_RED;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_cnt_q  <= sec_cnt_d;
      ped_pend_q <= ped_pend_d;
      blink_q    <= blink_d;
      we_q       <= we_d;
      ns_q       <= ns_d;
      walk_q     <= walk_d;
    end
  end

  assign bus.lightWE = we_q;
  assign bus.lightNS = ns_q;
  assign bus.walk    = walk_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: expected per-cycle {WE, NS, walk} words are queued as
// each scenario is driven and popped one per clock after the rising edge.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  logic rst;

  traffic_light_if bus ();

  traffic_light_ctrl #(
    .CLK_PER_SEC(4),
    .GREEN_SEC  (3),
    .YELLOW_SEC (1),
    .ALLRED_SEC (1),
    .WALK_SEC   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] E_WEG  = 7'b001_100_0;
  localparam logic [6:0] E_WEY  = 7'b010_100_0;
  localparam logic [6:0] E_RED  = 7'b100_100_0;
  localparam logic [6:0] E_NSG  = 7'b100_001_0;
  localparam logic [6:0] E_NSY  = 7'b100_010_0;
  localparam logic [6:0] E_WALK = 7'b100_100_1;
  localparam logic [6:0] E_FON  = 7'b010_010_0;
  localparam logic [6:0] E_FOFF = 7'b000_000_0;

  int total = 0;
  int bad   = 0;
  logic [6:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %b want %b", tag, $time, got, exp);
    end
  endtask

  task automatic push_n(input logic [6:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // One full WE/NS cycle: 12/4/4/12/4/4 cycles.
  task automatic push_cycle();
    push_n(E_WEG, 12);
    push_n(E_WEY, 4);
    push_n(E_RED, 4);
    push_n(E_NSG, 12);
    push_n(E_NSY, 4);
    push_n(E_RED, 4);
  endtask

  // Compare the current cycle, then advance to just after the next edge.
  task automatic run(input int n, input string tag);
    logic [6:0] obs;
    for (int i = 0; i < n; i++) begin
      obs = {bus.lightWE, bus.lightNS, bus.walk};
      if (exp_q.size() == 0) begin
        check_eq(tag, obs, 7'bxxxxxxx);
      end else begin
        check_eq(tag, obs, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
    end
  endtask

  // After this returns the DUT is in the first WE_GREEN cycle.
  task automatic do_reset();
    bus.ped_req  = 1'b0;
    bus.flash_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.ped_req  = 1'b0;
    bus.flash_en = 1'b0;

    // Free run: reset values, phase lengths, repeat of the sequence.
    do_reset();
    push_cycle();
    push_n(E_WEG, 12);
    run(52, "free_run");

    // Pedestrian pulse in NS_GREEN; second pulse during walk ignored.
    do_reset();
    push_n(E_WEG, 12);
    push_n(E_WEY, 4);
    push_n(E_RED, 4);
    run(20, "ped_pre");
    push_n(E_NSG, 12);
    push_n(E_NSY, 4);
    push_n(E_RED, 4);
    push_n(E_WALK, 8);
    push_n(E_RED, 4);
    push_cycle();
    push_n(E_WEG, 4);
    bus.ped_req = 1'b1;
    run(1, "ped_pulse");
    bus.ped_req = 1'b0;
    run(21, "ped_to_walk");
    bus.ped_req = 1'b1;
    run(1, "ped_in_walk");
    bus.ped_req = 1'b0;
    run(53, "ped_after");

    // Night mode requested mid green: green completes, FLASH at CLR_A exit.
    do_reset();
    push_n(E_WEG, 12);
    push_n(E_WEY, 4);
    push_n(E_RED, 4);
    push_n(E_FON, 4);
    push_n(E_FOFF, 4);
    push_n(E_FON, 4);
    push_n(E_FOFF, 4);
    run(4, "flash_pre");
    bus.flash_en = 1'b1;
    run(32, "flash_on");

    // Drop night mode: leave on next tick via CLR_B.
    bus.flash_en = 1'b0;
    push_n(E_FON, 4);
    push_n(E_RED, 4);
    push_n(E_WEG, 12);
    run(20, "flash_exit");

    // Pending request plus night mode at CLR_B: FLASH first, then walk.
    do_reset();
    push_n(E_WEG, 12);
    push_n(E_WEY, 4);
    push_n(E_RED, 4);
    push_n(E_NSG, 12);
    push_n(E_NSY, 4);
    push_n(E_RED, 4);
    push_n(E_FON, 4);
    push_n(E_FOFF, 4);
    run(20, "prio_pre");
    bus.ped_req = 1'b1;
    run(1, "prio_ped");
    bus.ped_req = 1'b0;
    run(11, "prio_nsg");
    bus.flash_en = 1'b1;
    run(16, "prio_flash");
    bus.flash_en = 1'b0;
    push_n(E_FON, 4);
    push_n(E_RED, 4);
    push_n(E_WALK, 8);
    push_n(E_RED, 4);
    push_n(E_WEG, 4);
    run(24, "prio_walk");

    // Reset mid NS_YELLOW drops the pending request.
    do_reset();
    push_n(E_WEG, 12);
    push_n(E_WEY, 4);
    push_n(E_RED, 4);
    push_n(E_NSG, 12);
    push_n(E_NSY, 3);
    bus.ped_req = 1'b1;
    run(1, "rst_ped");
    bus.ped_req = 1'b0;
    run(33, "rst_pre");
    rst = 1'b1;
    run(1, "rst_edge");
    rst = 1'b0;
    push_cycle();
    push_n(E_WEG, 4);
    run(44, "rst_after");

    check_eq("queue_empty", 7'(exp_q.size()), 7'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
